cu_multicycle_param: RTL
========================

Name: cu_multicycle_param

Overview:
- Parametrised multicycle control unit. Next generation of the team's 4-register, 20-bit-instruction CU.
- Generalised in data width, register count and field widths. Adds:
  - a valid/ready instruction handshake
  - a memory wait state with timeout
  - an optional hardwired zero register
  - a debug register-file read port
- Sits between the instruction source and the ALU/data-memory datapath. It drives the operands, offset, opcode and mux selects, and writes `result` back into its register file.

Parameters:
- DATA_WIDTH, 8, register and operand width.
- REG_ADDR_BITS, 2, register-index width; REGS = 2**REG_ADDR_BITS.
- OFFSET_WIDTH, 8, immediate offset width.
- OPCODE_WIDTH, 4, ALU opcode width.
- INSTR_WIDTH, 2+3*REG_ADDR_BITS+OFFSET_WIDTH+OPCODE_WIDTH (20 at defaults), derived, not overridable.
- MEM_WAIT_MAX, 15, maximum MEM_ACCESS cycles before abort.
- ZERO_REG, 0, when 1, writes to reg 0 are discarded and reg 0 reads as 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  CU can accept; high only in IDLE.
- instr  in  INSTR_WIDTH  fields from MSB down: type[2], rd, rs1, rs2, offset, opcode.
- result  in  DATA_WIDTH  ALU or data-memory result for write-back.
- mem_ready  in  1  data memory has completed the access.
- operand1  out  DATA_WIDTH  rf[rs1].
- operand2  out  DATA_WIDTH  rf[rs2] for std_op; rf[rd] for load/store.
- offset  out  OFFSET_WIDTH  immediate.
- opcode  out  OPCODE_WIDTH  ALU opcode.
- sel1  out  1  1 = pass ALU result, 0 = pass data_out.
- sel3  out  1  1 = pass offset.
- w_r  out  1  data-memory write strobe.
- busy  out  1  state != IDLE.
- retire  out  1  one-cycle pulse: instruction completed.
- err  out  1  one-cycle pulse: memory timeout abort.
- dbg_addr  in  REG_ADDR_BITS  debug read index.
- dbg_data  out  DATA_WIDTH  combinational rf[dbg_addr].

Behaviour:
Instruction types:
- 00 NOP
- 01 std_op
- 10 loadR
- 11 storeR

Reset (rst low, asynchronous):
- State goes to IDLE.
- rf[i] = i, truncated to DATA_WIDTH; rf[0] = 0.
- operand1/2 and offset = 0; opcode = all ones.
- sel1, sel3, w_r, retire, err = 0.
- Reset asserted mid-instruction aborts it with no write-back.

States: IDLE, DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK. Any unreachable encoding returns to IDLE on the next edge.

IDLE:
- instr_ready = 1.
- On instr_valid & instr_ready, instr is latched into an internal register.
- NOP: go to IDLE with retire pulsed next cycle.
- Otherwise go to DECODE.
- The instr input is ignored outside IDLE.

DECODE -> EXECUTE:
- On this edge operand1, operand2, offset, opcode, sel1 and sel3 are registered.
- std_op: sel1=1, sel3=0.
- load/store: sel1=0, sel3=1.
- These outputs hold until the next DECODE or reset.

EXECUTE:
- std_op goes to WRITE_BACK.
- load/store go to MEM_ACCESS.
- For store, w_r is registered to 1 on this edge.

MEM_ACCESS:
- A wait counter starts at 0 and increments every cycle while mem_ready = 0.
- When mem_ready = 1 is sampled:
  - load goes to WRITE_BACK;
  - store goes to IDLE with w_r cleared and retire pulsed.
- If the count reaches MEM_WAIT_MAX with mem_ready still low:
  - go to IDLE;
  - w_r cleared;
  - err pulsed, retire not pulsed;
  - no register write.

WRITE_BACK:
- On the exit edge, rf[rd] <= result, unless ZERO_REG=1 and rd=0.
- Go to IDLE; retire pulses in the first IDLE cycle.

Latency from accept edge to instr_ready high again:
- NOP: 1 cycle.
- std_op: 4 cycles.
- store: 4 + wait cycles.
- load: 5 + wait cycles.

Hazards and debug port:
- The write completes before the next DECODE, so there are no hazards.
- dbg_data reflects a write from the cycle after the write edge.

Decomposition:
- Package cu_pkg:
  - state encoding
  - instruction-type constants (NOP, STD, LOAD, STORE)
  - field-offset functions computing field positions from REG_ADDR_BITS, OFFSET_WIDTH and OPCODE_WIDTH
- One sub-module, cu_regfile:
  - REGS x DATA_WIDTH
  - two combinational read ports plus the debug read port
  - one synchronous write port
  - async-low reset to index values
  - ZERO_REG handling

Test Plan:
1. Reset, then read all debug addresses -> dbg_data = 0,1,2,3; opcode=4'hF, instr_ready=1, busy=0.
2. std_op 0x76000 (rd=3, rs1=1, rs2=2), result=8'h2A in WRITE_BACK -> operand1=1, operand2=2, sel1=1, sel3=0; rf[3]=8'h2A; retire 4 cycles after accept.
3. loadR 0xA4050 (rd=2, rs1=1, offset=5), mem_ready low 3 cycles then high, result=8'h55 -> operand1=1, offset=5, sel3=1, w_r=0 throughout; rf[2]=8'h55; ready 8 cycles after accept.
4. storeR 0xD8030 (rd=1, rs1=2, offset=3), mem_ready high immediately -> operand1=2, operand2=1; w_r high exactly 1 cycle; no rf change; retire pulse.
5. storeR with mem_ready held low -> w_r high 16 cycles, then err pulse; retire stays 0; back in IDLE; rf unchanged.
6. ZERO_REG=1, std_op rd=0, result=8'hFF -> rf[0] stays 0. Separately, drop rst mid-EXECUTE -> immediate IDLE; outputs and rf restored to reset values.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and instruction field layout for the multicycle control unit.
package cu_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DECODE     = 3'd1,
        S_EXECUTE    = 3'd2,
        S_MEM_ACCESS = 3'd3,
        S_WRITE_BACK = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        T_NOP   = 2'b00,
        T_STD   = 2'b01,
        T_LOAD  = 2'b10,
        T_STORE = 2'b11
    } itype_t;

    // Instruction layout, MSB down: type[2], rd, rs1, rs2, offset, opcode.
    function automatic int instr_width(input int rab, input int offw, input int opw);
        return 2 + 3 * rab + offw + opw;
    endfunction

    function automatic int offset_lsb(input int rab, input int offw, input int opw);
        return opw + 0 * (rab + offw);
    endfunction

    function automatic int rs2_lsb(input int rab, input int offw, input int opw);
        return opw + offw + 0 * rab;
    endfunction

    function automatic int rs1_lsb(input int rab, input int offw, input int opw);
        return opw + offw + rab;
    endfunction

    function automatic int rd_lsb(input int rab, input int offw, input int opw);
        return opw + offw + 2 * rab;
    endfunction

    function automatic int type_lsb(input int rab, input int offw, input int opw);
        return opw + offw + 3 * rab;
    endfunction

endpackage

// File: rtl/cu_multicycle_param_regfile.sv
// Register file: two operand read ports, a debug read port, one write port.
// Resets each register to its own index; optional hardwired-zero register 0.
module cu_regfile
    import cu_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int REG_ADDR_BITS = 2,
    parameter int ZERO_REG      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_BITS-1:0] ra1,
    input  logic [REG_ADDR_BITS-1:0] ra2,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    rd1,
    output logic [DATA_WIDTH-1:0]    rd2,
    output logic [DATA_WIDTH-1:0]    dbg_data,
    input  logic                     we,
    input  logic [REG_ADDR_BITS-1:0] wa,
    input  logic [DATA_WIDTH-1:0]    wd
);

    localparam int REGS = 1 << REG_ADDR_BITS;

    logic [REGS-1:0][DATA_WIDTH-1:0] rf;
    logic                            wr_block;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign wr_block = (ZERO_REG != 0) && (wa == '0);

    // Storage: async reset to index values, synchronous write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REGS; i++) rf[i] <= DATA_WIDTH'(i);
        end else if (we && !wr_block) begin
            rf[wa] <= wd;
        end
    end

    // Combinational reads; register 0 forced to zero when hardwired.
    always_comb begin
        rd1      = ((ZERO_REG != 0) && (ra1 == '0))      ? '0 : rf[ra1];
        rd2      = ((ZERO_REG != 0) && (ra2 == '0))      ? '0 : rf[ra2];
        dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : rf[dbg_addr];
    end

endmodule

// File: rtl/cu_multicycle_param.sv
// Multicycle control unit: accepts one instruction at a time over valid/ready,
// steps it through DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK and drives the datapath.
module cu_multicycle_param
    import cu_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int REG_ADDR_BITS = 2,
    parameter int OFFSET_WIDTH  = 8,
    parameter int OPCODE_WIDTH  = 4,
    parameter int MEM_WAIT_MAX  = 15,
    parameter int ZERO_REG      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [instr_width(REG_ADDR_BITS, OFFSET_WIDTH, OPCODE_WIDTH)-1:0] instr,
    input  logic [DATA_WIDTH-1:0]    result,
    input  logic                     mem_ready,
    output logic [DATA_WIDTH-1:0]    operand1,
    output logic [DATA_WIDTH-1:0]    operand2,
    output logic [OFFSET_WIDTH-1:0]  offset,
    output logic [OPCODE_WIDTH-1:0]  opcode,
    output logic                     sel1,
    output logic                     sel3,
    output logic                     w_r,
    output logic                     busy,
    output logic                     retire,
    output logic                     err,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_data
);

    localparam int INSTR_WIDTH = instr_width(REG_ADDR_BITS, OFFSET_WIDTH, OPCODE_WIDTH);
    localparam int TYPE_LSB    = type_lsb(REG_ADDR_BITS, OFFSET_WIDTH, OPCODE_WIDTH);
    localparam int RD_LSB      = rd_lsb(REG_ADDR_BITS, OFFSET_WIDTH, OPCODE_WIDTH);
    localparam int RS1_LSB     = rs1_lsb(REG_ADDR_BITS, OFFSET_WIDTH, OPCODE_WIDTH);
    localparam int RS2_LSB     = rs2_lsb(REG_ADDR_BITS, OFFSET_WIDTH, OPCODE_WIDTH);
    localparam int OFF_LSB     = offset_lsb(REG_ADDR_BITS, OFFSET_WIDTH, OPCODE_WIDTH);
    localparam int WCNT_W      = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_WAIT_MAX);

    state_t                    state, state_nxt;
    logic [INSTR_WIDTH-1:0]    ir;
    logic [WCNT_W-1:0]         wcnt;

    itype_t                    ityp, in_typ;
    logic [REG_ADDR_BITS-1:0]  f_rd, f_rs1, f_rs2, ra2;
    logic [DATA_WIDTH-1:0]     rd1, rd2;

    logic ir_load, dec_load, wr_set, wr_clr, retire_nxt, err_nxt;
    logic cnt_clr, cnt_inc, rf_we;

    // Field extraction from the latched instruction (and type of the offered one).
    always_comb begin
        in_typ = itype_t'(instr[TYPE_LSB +: 2]);
        ityp   = itype_t'(ir[TYPE_LSB +: 2]);
        f_rd   = ir[RD_LSB  +: REG_ADDR_BITS];
        f_rs1  = ir[RS1_LSB +: REG_ADDR_BITS];
        f_rs2  = ir[RS2_LSB +: REG_ADDR_BITS];
        // Memory ops carry the data register in rd, so port 2 reads rd.
        ra2    = (ityp == T_STD) ? f_rs2 : f_rd;
    end

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);

    cu_regfile #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_BITS (REG_ADDR_BITS),
        .ZERO_REG      (ZERO_REG)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .ra1      (f_rs1),
        .ra2      (ra2),
        .dbg_addr (dbg_addr),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (f_rd),
        .wd       (result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt  = state;
        ir_load    = 1'b0;
        dec_load   = 1'b0;
        wr_set     = 1'b0;
        wr_clr     = 1'b0;
        retire_nxt = 1'b0;
        err_nxt    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        rf_we      = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_load = 1'b1;
                    if (in_typ == T_NOP) retire_nxt = 1'b1;
                    else                 state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                dec_load  = 1'b1;
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                cnt_clr = 1'b1;
                if (ityp == T_STD) begin
                    state_nxt = S_WRITE_BACK;
                end else begin
                    state_nxt = S_MEM_ACCESS;
                    wr_set    = (ityp == T_STORE);
                end
            end
            S_MEM_ACCESS: begin
                if (mem_ready) begin
                    if (ityp == T_LOAD) begin
                        state_nxt = S_WRITE_BACK;
                    end else begin
                        state_nxt  = S_IDLE;
                        wr_clr     = 1'b1;
                        retire_nxt = 1'b1;
                    end
                end else if (wcnt == WAIT_MAX) begin
                    // Memory never answered: abandon without write-back.
                    state_nxt = S_IDLE;
                    wr_clr    = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WRITE_BACK: begin
                rf_we      = 1'b1;
                retire_nxt = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Instruction latch and memory wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir   <= '0;
            wcnt <= '0;
        end else begin
            if (ir_load) ir <= instr;
            if (cnt_clr)      wcnt <= '0;
            else if (cnt_inc) wcnt <= wcnt + 1'b1;
        end
    end

    // Datapath controls: operands captured leaving DECODE, strobes and pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            operand1 <= '0;
            operand2 <= '0;
            offset   <= '0;
            opcode   <= '1;
            sel1     <= 1'b0;
            sel3     <= 1'b0;
            w_r      <= 1'b0;
            retire   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (dec_load) begin
                operand1 <= rd1;
                operand2 <= rd2;
                offset   <= ir[OFF_LSB +: OFFSET_WIDTH];
                opcode   <= ir[OPCODE_WIDTH-1:0];
                sel1     <= (ityp == T_STD);
                sel3     <= (ityp != T_STD);
            end
            if (wr_set)      w_r <= 1'b1;
            else if (wr_clr) w_r <= 1'b0;
            retire <= retire_nxt;
            err    <= err_nxt;
        end
    end

endmodule
